// File: rtl/led_blinker_bank.sv
// Bank of independent LED channels (off / on / blink / triggered pulse) with a runtime config port.
// All outputs registered, config takes effect one cycle after the strobe; no backpressure, bad writes are flagged.
module led_blinker_bank #(
  parameter int NUM_CH       = 8,
  parameter int CNT_W        = 28,
  parameter int DEFAULT_HALF = 50000000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic              sync,
  input  logic [NUM_CH-1:0] trig,
  output logic [NUM_CH-1:0] led,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PULSE = 2'b11
  } mode_e;

  mode_e             r_mode [NUM_CH];
  logic [CNT_W-1:0]  r_half [NUM_CH];
  logic [CNT_W-1:0]  r_cnt  [NUM_CH];
  logic [NUM_CH-1:0] r_led;
  logic [NUM_CH-1:0] r_trig_d;
  logic              r_cfg_err;

  logic [CNT_W-1:0]  w_last [NUM_CH];
  logic [NUM_CH-1:0] w_rise;
  logic              w_ch_ok;

  assign w_ch_ok = (int'(cfg_ch) < NUM_CH);
  assign w_rise  = trig & ~r_trig_d;
  assign led     = r_led;
  assign cfg_err = r_cfg_err;

  // Terminal count is h-1 with h = max(half,1), so half=0 behaves like half=1.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_last[i] = (r_half[i] == '0) ? '0 : r_half[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_cfg_err <= 1'b0;
      r_led     <= '0;
      r_trig_d  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_mode[i] <= MODE_BLINK;
        r_half[i] <= CNT_W'(DEFAULT_HALF);
        r_cnt[i]  <= '0;
      end
    end else begin
      r_cfg_err <= cfg_we & ~w_ch_ok;
      r_trig_d  <= trig;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we && w_ch_ok && (cfg_ch == CH_W'(i))) begin
          r_mode[i] <= mode_e'(cfg_mode);
          r_half[i] <= cfg_half;
          r_cnt[i]  <= '0;
          r_led[i]  <= (cfg_mode == MODE_ON);
        end else begin
          unique case (r_mode[i])
            MODE_OFF: begin
              r_cnt[i] <= '0;
              r_led[i] <= 1'b0;
            end
            MODE_ON: begin
              r_cnt[i] <= '0;
              r_led[i] <= 1'b1;
            end
            MODE_BLINK: begin
              if (sync) begin
                r_cnt[i] <= '0;
                r_led[i] <= 1'b0;
              end else if (r_cnt[i] >= w_last[i]) begin
                r_cnt[i] <= '0;
                r_led[i] <= ~r_led[i];
              end else begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
              end
            end
            MODE_PULSE: begin
              // A fresh edge restarts the window even while the pulse is running.
              if (w_rise[i]) begin
                r_cnt[i] <= '0;
                r_led[i] <= 1'b1;
              end else if (r_led[i]) begin
                if (r_cnt[i] >= w_last[i]) begin
                  r_cnt[i] <= '0;
                  r_led[i] <= 1'b0;
                end else begin
                  r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
              end else begin
                r_cnt[i] <= '0;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_blinker_bank.sv
// Bench for led_blinker_bank: a 4-channel instance plus a 3-channel instance sharing all stimulus,
// so that cfg_ch=3 is an out-of-range write for the second one.
module tb_led_blinker_bank;

  localparam int NC = 4;
  localparam int CW = 8;
  localparam int DH = 5;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_half;
  logic          sync;
  logic [NC-1:0] trig;
  logic [NC-1:0] led;
  logic          cfg_err;
  logic [2:0]    led3;
  logic          cfg_err3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  led_blinker_bank #(.NUM_CH(NC), .CNT_W(CW), .DEFAULT_HALF(DH)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .sync(sync), .trig(trig),
    .led(led), .cfg_err(cfg_err)
  );

  led_blinker_bank #(.NUM_CH(3), .CNT_W(CW), .DEFAULT_HALF(DH)) u_dut3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .sync(sync), .trig(trig[2:0]),
    .led(led3), .cfg_err(cfg_err3)
  );

  // Reference model: blink phase as elapsed cycles since the last realign,
  // pulse as cycles remaining in the current window.
  int m_mode  [2][4];
  int m_half  [2][4];
  int m_ph    [2][4];
  int m_rem   [2][4];
  bit m_led   [2][4];
  bit m_tprev [2][4];
  bit m_err   [2];

  function automatic int nch_of(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      m_err[d] = sys_rst_n && cfg_we && (int'(cfg_ch) >= nch_of(d));
      for (int c = 0; c < nch_of(d); c++) begin
        if (!sys_rst_n) begin
          m_mode[d][c] = 2; m_half[d][c] = DH; m_ph[d][c] = 0;
          m_rem[d][c]  = 0; m_led[d][c]  = 0;  m_tprev[d][c] = 0;
        end else begin
          int h;
          bit rise;
          h    = (m_half[d][c] == 0) ? 1 : m_half[d][c];
          rise = trig[c] && !m_tprev[d][c];
          if (cfg_we && int'(cfg_ch) == c) begin
            m_mode[d][c] = int'(cfg_mode);
            m_half[d][c] = int'(cfg_half);
            m_ph[d][c]   = 0;
            m_rem[d][c]  = 0;
            m_led[d][c]  = (cfg_mode == 2'd1);
          end else begin
            case (m_mode[d][c])
              0: m_led[d][c] = 0;
              1: m_led[d][c] = 1;
              2: begin
                if (sync) begin
                  m_ph[d][c] = 0; m_led[d][c] = 0;
                end else begin
                  m_ph[d][c] = m_ph[d][c] + 1;
                  if (m_ph[d][c] % h == 0) m_led[d][c] = !m_led[d][c];
                end
              end
              default: begin
                if (rise) begin
                  m_rem[d][c] = h; m_led[d][c] = 1;
                end else if (m_rem[d][c] > 0) begin
                  m_rem[d][c] = m_rem[d][c] - 1;
                  m_led[d][c] = (m_rem[d][c] > 0);
                end
              end
            endcase
          end
          m_tprev[d][c] = trig[c];
        end
      end
    end
  endfunction

  function automatic logic [3:0] exp_led(int d);
    logic [3:0] v;
    v = '0;
    for (int c = 0; c < nch_of(d); c++) v[c] = m_led[d][c];
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model consumes the inputs present at the edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge sys_clk);
    model_step();
    #1;
    check("led4", {28'd0, led}, {28'd0, exp_led(0)});
    check("err4", {31'd0, cfg_err}, {31'd0, m_err[0]});
    check("led3", {29'd0, led3}, {28'd0, exp_led(1)});
    check("err3", {31'd0, cfg_err3}, {31'd0, m_err[1]});
  endtask

  task automatic write(input logic [1:0] ch, input logic [1:0] mode, input logic [CW-1:0] half);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_half = half;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    int cnt_hi;
    logic a, b;
    sys_rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_half = '0; sync = 1'b0; trig = '0;

    // Reset state, with inputs active to show they are ignored.
    cfg_we = 1'b1; sync = 1'b1; trig = 4'hF;
    step();
    cfg_we = 1'b0; sync = 1'b0; trig = '0;
    step();
    check("rst_led", {28'd0, led}, 32'd0);
    check("rst_err", {31'd0, cfg_err}, 32'd0);

    // Default blink: first toggle after DH cycles, period 2*DH, all channels in phase.
    sys_rst_n = 1'b1;
    repeat (4) step();
    check("blink_pre_toggle", {28'd0, led}, 32'h0);
    step();
    check("blink_first_toggle", {28'd0, led}, 32'hF);
    repeat (5) step();
    check("blink_second_toggle", {28'd0, led}, 32'h0);

    // ch2 at half=3, then a sync realigns every blink channel.
    write(2'd2, 2'b10, 8'd3);
    repeat (7) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_all_low", {28'd0, led}, 32'h0);
    repeat (12) step();

    // Pulse: held trigger gives exactly one 4-cycle pulse.
    write(2'd1, 2'b11, 8'd4);
    cnt_hi = 0;
    trig[1] = 1'b1;
    repeat (10) begin step(); cnt_hi += int'(led[1]); end
    check("pulse_len", cnt_hi, 32'd4);

    // Retrigger two cycles into the pulse stretches it to 6 cycles.
    trig[1] = 1'b0; step();
    cnt_hi = 0;
    trig[1] = 1'b1; step(); cnt_hi += int'(led[1]);
    trig[1] = 1'b0; step(); cnt_hi += int'(led[1]);
    trig[1] = 1'b1;
    repeat (10) begin step(); cnt_hi += int'(led[1]); end
    check("pulse_retrig_len", cnt_hi, 32'd6);

    // Out-of-range write on the 3-channel instance; half=0 blink toggles every cycle.
    write(2'd3, 2'b01, 8'd9);
    check("oor_err3", {31'd0, cfg_err3}, 32'd1);
    check("oor_err4", {31'd0, cfg_err}, 32'd0);
    step();
    check("oor_err3_clear", {31'd0, cfg_err3}, 32'd0);
    write(2'd0, 2'b10, 8'd0);
    step(); a = led[0];
    step(); b = led[0];
    check("half0_toggle", {31'd0, a ^ b}, 32'd1);

    // One-cycle reset in the middle of a pulse and a blink.
    trig[1] = 1'b0; step();
    trig[1] = 1'b1; step();
    sys_rst_n = 1'b0; trig = '0;
    step();
    check("midrst_led", {28'd0, led}, 32'h0);
    sys_rst_n = 1'b1;
    repeat (5) step();
    check("midrst_default_blink", {28'd0, led}, 32'hF);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_half  = 8'($urandom_range(0, 6));
      sync      = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) trig = 4'($urandom_range(0, 15));
      sys_rst_n = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
